add_result_checker: RTL
=======================

# add_result_checker

Synthesizable result checker for the 32-bit adder datapath: it samples the operands and carry-in presented to the adder, computes the golden sum internally, and delays it through a valid-tagged pipeline that matches the adder's latency. It compares the golden value against the adder's registered `s`/`cout` and keeps pass/fail statistics plus a sticky error flag. It sits on the result side of the adder, as the consumer end of the operand stream that the stimulus side drives. It can run in simulation or on silicon as a built-in self-check.

## Interface
Parameters:
- `N`, 32: operand/sum width.
- `LATENCY`, 1: adder latency in clock edges, from operand sample to valid `s`/`cout`; legal range 1..8.
- `CNT_W`, 16: width of pass/fail counters.

Ports:
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `clear` input, 1 bit: synchronous clear of statistics and pipeline.
- `in_valid` input, 1 bit: `a`/`b`/`cin` are presented to the adder this cycle.
- `a` input, N bits: adder operand A.
- `b` input, N bits: adder operand B.
- `cin` input, 1 bit: adder carry-in.
- `s` input, N bits: adder sum output.
- `cout` input, 1 bit: adder carry-out.
- `mismatch` output, 1 bit: one-cycle pulse on a failed compare.
- `err` output, 1 bit: sticky; set on first failure.
- `pass_cnt` output, CNT_W bits: count of passing compares.
- `fail_cnt` output, CNT_W bits: count of failing compares.

## Operation
- Golden value: `exp = a + b + cin`, computed at N+1 bits. `exp[N]` is the expected `cout`; `exp[N-1:0]` is the expected `s`. Wrap-around is natural; there is no overflow flag.
- Pipeline: `LATENCY` stages. Each stage holds a valid bit, `exp`, and (when enabled) `a`/`b`/`cin`.
  - Stage 0 loads on every edge; its valid bit = `in_valid`.
  - Stages shift unconditionally. There is no backpressure.
- Compare: at each edge, if the last-stage valid bit is 1, `{cout,s}` is compared with the last-stage `exp`.
  - Equal: `pass_cnt` increments.
  - Unequal: `fail_cnt` increments, `mismatch` is set for one cycle, and `err` is set.
- Counters saturate at all-ones; they never wrap.
- `err` is cleared only by `rst_n` or `clear`.
- `clear`: at the edge it is sampled, it zeroes the counters, `err`, `mismatch`, and all pipeline valid bits.
  - An `in_valid` sample on the same edge is discarded.
  - A compare due on the same edge is discarded and not counted.
- Reset (`rst_n` low, at any time including mid-stream): all outputs go to 0 and all pipeline valid bits go to 0 immediately. The checker resumes cleanly on the first `in_valid` after release.

## Timing
- Operands are sampled at edge k. The DUT result is compared at edge k+`LATENCY`. Statistics and `mismatch` are visible after edge k+`LATENCY`.
- Back-to-back `in_valid` every cycle is fully supported: one compare per cycle at steady state.
- `mismatch` is high for exactly one cycle per failing compare. Consecutive failures keep it high on consecutive cycles.
- Reset values: `mismatch`=0, `err`=0, `pass_cnt`=0, `fail_cnt`=0. With the capture feature enabled, all `ff_*` outputs = 0.
- `s`/`cout` are only sampled on edges where a compare is due; their values at other times are ignored.

## Configuration
- `ADD_CHK_FIRST_FAIL_EN` defined: adds these outputs:
  - `ff_valid` (1 bit)
  - `ff_a` (N bits)
  - `ff_b` (N bits)
  - `ff_cin` (1 bit)
  - `ff_got` (N+1 bits, the observed `{cout,s}`)
  - `ff_exp` (N+1 bits)
  
  Pipeline stages also carry `a`/`b`/`cin`. On the first failing compare after reset or `clear`, the captured fields load and `ff_valid` is set. Later failures do not overwrite them. `clear`/`rst_n` zero all `ff_*` outputs.
- Undefined: none of these ports or pipeline fields exist; the remaining behaviour is identical.

## Test plan
- LATENCY=1, model adder correct. Drive `a`=5, `b`=7, `cin`=0 with `in_valid` one cycle; feed `s`=12, `cout`=0 on the next edge. Required: `pass_cnt`=1, `fail_cnt`=0, `err`=0.
- Drive `a`=0xFFFFFFFF, `b`=1, `cin`=0; inject `s`=0, `cout`=0 instead of the correct `cout`=1. Required: one-cycle `mismatch`, `fail_cnt`=1, `err`=1. With the macro: `ff_got`=0x0_00000000, `ff_exp`=0x1_00000000.
- LATENCY=3, `in_valid` every cycle for 20 cycles with `a`=`b`=count, `cin`=0, correct DUT. Required: `pass_cnt`=20, first compare exactly 3 edges after first sample.
- CNT_W=4, 20 passing compares. Required: `pass_cnt`=15 (saturated), `fail_cnt`=0.
- Two failures, then assert `clear` for one cycle while a compare is due and `in_valid`=1. Required: counters=0, `err`=0, that compare not counted, no compare 1 edge after `clear` for the discarded sample.
- Pull `rst_n` low mid-stream with LATENCY=2 and samples in flight. Required: immediate zero outputs; after release with `in_valid` held low, no compares occur and counters stay 0.

Source files
------------

// File: rtl/add_result_checker.sv
// rtl/add_result_checker.sv - golden-sum checker for the pipelined N-bit adder; optional capture via ADD_CHK_FIRST_FAIL_EN
module add_result_checker #(
    parameter int N       = 32,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             cin,
    input  logic [N-1:0]     s,
    input  logic             cout,
    output logic             mismatch,
    output logic             err,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
`ifdef ADD_CHK_FIRST_FAIL_EN
    ,
    output logic             ff_valid,
    output logic [N-1:0]     ff_a,
    output logic [N-1:0]     ff_b,
    output logic             ff_cin,
    output logic [N:0]       ff_got,
    output logic [N:0]       ff_exp
`endif
);

    logic [N:0]         exp_in;
    logic [LATENCY-1:0] pv;
    logic [N:0]         pe [LATENCY];
    logic [N:0]         got;
    logic               due;
    logic               bad;

    assign exp_in = {1'b0, a} + {1'b0, b} + (N+1)'(cin);
    assign got    = {cout, s};
    assign due    = pv[LATENCY-1];
    assign bad    = due && (got != pe[LATENCY-1]);

    // Only the valid bits need reset/clear; data is meaningless without them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
        end else if (clear) begin
            pv <= '0;
        end else begin
            pv[0] <= in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                pv[i] <= pv[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        pe[0] <= exp_in;
        for (int i = 1; i < LATENCY; i++) begin
            pe[i] <= pe[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch <= 1'b0;
            err      <= 1'b0;
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (clear) begin
            mismatch <= 1'b0;
            err      <= 1'b0;
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            mismatch <= bad;
            if (bad) begin
                err <= 1'b1;
                if (fail_cnt != '1) begin
                    fail_cnt <= fail_cnt + CNT_W'(1);
                end
            end else if (due && (pass_cnt != '1)) begin
                pass_cnt <= pass_cnt + CNT_W'(1);
            end
        end
    end

`ifdef ADD_CHK_FIRST_FAIL_EN
    logic [N-1:0]       pa [LATENCY];
    logic [N-1:0]       pb [LATENCY];
    logic [LATENCY-1:0] pc;

    always_ff @(posedge clk) begin
        pa[0] <= a;
        pb[0] <= b;
        pc[0] <= cin;
        for (int i = 1; i < LATENCY; i++) begin
            pa[i] <= pa[i-1];
            pb[i] <= pb[i-1];
            pc[i] <= pc[i-1];
        end
    end

    // Capture only the first failure so the root cause is not overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_valid <= 1'b0;
            ff_a     <= '0;
            ff_b     <= '0;
            ff_cin   <= 1'b0;
            ff_got   <= '0;
            ff_exp   <= '0;
        end else if (clear) begin
            ff_valid <= 1'b0;
            ff_a     <= '0;
            ff_b     <= '0;
            ff_cin   <= 1'b0;
            ff_got   <= '0;
            ff_exp   <= '0;
        end else if (bad && !ff_valid) begin
            ff_valid <= 1'b1;
            ff_a     <= pa[LATENCY-1];
            ff_b     <= pb[LATENCY-1];
            ff_cin   <= pc[LATENCY-1];
            ff_got   <= got;
            ff_exp   <= pe[LATENCY-1];
        end
    end
`endif

endmodule
